// File: rtl/iq_dual_queue_if.sv
// Fetch-to-issue queue bus: two write lanes in, two read lanes out, flush and status.
// master drives the queue (upstream/downstream side), slave is the queue itself.
interface iq_dual_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
);
  logic              flush_i;
  logic [1:0]        we_i;
  logic [DATA_W-1:0] wdata0_i;
  logic [DATA_W-1:0] wdata1_i;
  logic              allowin_o;
  logic [1:0]        pop_i;
  logic [DATA_W-1:0] rdata0_o;
  logic [DATA_W-1:0] rdata1_o;
  logic [1:0]        rvalid_o;
  logic [PTR_W:0]    count_o;
  logic              empty_o;
  logic              full_o;

  modport master (
    output flush_i, we_i, wdata0_i, wdata1_i, pop_i,
    input  allowin_o, rdata0_o, rdata1_o, rvalid_o, count_o, empty_o, full_o
  );

  modport slave (
    input  flush_i, we_i, wdata0_i, wdata1_i, pop_i,
    output allowin_o, rdata0_o, rdata1_o, rvalid_o, count_o, empty_o, full_o
  );
endinterface

// File: rtl/iq_dual_queue.sv
// Two-in/two-out circular instruction queue with wrap-safe PTR_W+1 pointers,
// conservative allowin back-pressure and single-cycle flush.
module iq_dual_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst_n,  // active-high synchronous reset
  iq_dual_queue_if.slave bus
);

  localparam logic [PTR_W:0] DualMax = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] DepthP  = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    wnum, pnum;
  logic [PTR_W-1:0]  wr0_idx, wr1_idx, rd0_idx, rd1_idx;
  logic [1:0]        weff, pmask, peff, rvalid;
  logic              allowin;

  always_comb begin
    count   = head_q - tail_q;
    allowin = count <= DualMax;
    rvalid  = {|count[PTR_W:1], |count};

    weff = 2'b00;
    if (allowin && (bus.we_i == 2'b01 || bus.we_i == 2'b11)) begin
      weff = bus.we_i;
    end
    // Over-pop of 11 at count 1 degrades to 01; a bare lane-1 pop is illegal.
    pmask = bus.pop_i & rvalid;
    peff  = (pmask == 2'b10) ? 2'b00 : pmask;

    wnum   = (PTR_W+1)'(weff[0]) + (PTR_W+1)'(weff[1]);
    pnum   = (PTR_W+1)'(peff[0]) + (PTR_W+1)'(peff[1]);
    head_d = head_q + wnum;
    tail_d = tail_q + pnum;

    wr0_idx = head_q[PTR_W-1:0];
    wr1_idx = wr0_idx + PTR_W'(1);
    rd0_idx = tail_q[PTR_W-1:0];
    rd1_idx = rd0_idx + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (bus.flush_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage is not reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (!rst_n && !bus.flush_i) begin
      if (weff[0]) mem_q[wr0_idx] <= bus.wdata0_i;
      if (weff[1]) mem_q[wr1_idx] <= bus.wdata1_i;
    end
  end

  assign bus.rdata0_o  = mem_q[rd0_idx];
  assign bus.rdata1_o  = mem_q[rd1_idx];
  assign bus.rvalid_o  = rvalid;
  assign bus.count_o   = count;
  assign bus.allowin_o = allowin;
  assign bus.empty_o   = (count == '0);
  assign bus.full_o    = (count == DepthP);

endmodule

// File: tb/tb_iq_dual_queue.sv
// Self-checking bench for iq_dual_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_iq_dual_queue;
  localparam int unsigned DataW = 32;
  localparam int unsigned Depth = 16;

  logic clk = 1'b0;
  logic rst_n;

  iq_dual_queue_if #(.DATA_W(DataW), .DEPTH(Depth)) bus ();

  iq_dual_queue #(.DATA_W(DataW), .DEPTH(Depth)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [DataW-1:0] mq[$];
  logic [DataW-1:0] dctr = 32'hC000_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = mq.size();
    check("count", 64'(bus.count_o), 64'(n));
    check("empty", 64'(bus.empty_o), 64'(n == 0));
    check("full", 64'(bus.full_o), 64'(n == Depth));
    check("allowin", 64'(bus.allowin_o), 64'((Depth - n) >= 2));
    check("rvalid", 64'(bus.rvalid_o), {62'd0, n >= 2, n >= 1});
    if (n >= 1) check("rdata0", 64'(bus.rdata0_o), 64'(mq[0]));
    if (n >= 2) check("rdata1", 64'(bus.rdata1_o), 64'(mq[1]));
  endtask

  // Apply one cycle of stimulus, advance the model by the queue rules, then check.
  task automatic cyc(input logic r, input logic f, input logic [1:0] we, input logic [1:0] pop,
                     input logic [DataW-1:0] d0, input logic [DataW-1:0] d1);
    bit allow;
    int npop;
    rst_n        = r;
    bus.flush_i  = f;
    bus.we_i     = we;
    bus.pop_i    = pop;
    bus.wdata0_i = d0;
    bus.wdata1_i = d1;
    if (r || f) begin
      mq.delete();
    end else begin
      allow = (Depth - mq.size()) >= 2;
      npop  = (pop == 2'b11) ? 2 : (pop == 2'b01) ? 1 : 0;
      if (npop > mq.size()) npop = mq.size();
      repeat (npop) void'(mq.pop_front());
      if (allow && we == 2'b01) mq.push_back(d0);
      if (allow && we == 2'b11) begin
        mq.push_back(d0);
        mq.push_back(d1);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic push(input logic [1:0] we, input logic [1:0] pop);
    cyc(1'b0, 1'b0, we, pop, dctr, dctr + 1);
    dctr += 2;
  endtask

  logic [DataW-1:0] exp_d;

  initial begin
    rst_n = 1'b1;
    bus.flush_i = 1'b0;
    bus.we_i = 2'b00;
    bus.pop_i = 2'b00;
    bus.wdata0_i = '0;
    bus.wdata1_i = '0;

    cyc(1'b1, 1'b0, 2'b00, 2'b00, '0, '0);
    cyc(1'b1, 1'b0, 2'b00, 2'b00, '0, '0);
    check("rst_count", 64'(bus.count_o), 64'd0);
    check("rst_empty", 64'(bus.empty_o), 64'd1);
    check("rst_allowin", 64'(bus.allowin_o), 64'd1);
    check("rst_rvalid", 64'(bus.rvalid_o), 64'd0);

    // Three single writes, then a dual pop
    cyc(1'b0, 1'b0, 2'b01, 2'b00, 32'hA0, '0);
    cyc(1'b0, 1'b0, 2'b01, 2'b00, 32'hA1, '0);
    cyc(1'b0, 1'b0, 2'b01, 2'b00, 32'hA2, '0);
    check("w3_count", 64'(bus.count_o), 64'd3);
    check("w3_rdata0", 64'(bus.rdata0_o), 64'hA0);
    check("w3_rdata1", 64'(bus.rdata1_o), 64'hA1);
    check("w3_rvalid", 64'(bus.rvalid_o), 64'd3);
    cyc(1'b0, 1'b0, 2'b00, 2'b11, '0, '0);
    check("pop_rdata0", 64'(bus.rdata0_o), 64'hA2);
    check("pop_rvalid", 64'(bus.rvalid_o), 64'd1);
    check("pop_count", 64'(bus.count_o), 64'd1);

    // Over-pop at count 1
    cyc(1'b0, 1'b0, 2'b00, 2'b11, '0, '0);
    check("overpop_count", 64'(bus.count_o), 64'd0);
    check("overpop_empty", 64'(bus.empty_o), 64'd1);

    // Odd fill to 15, back-pressure, then sustained dual traffic across wrap
    push(2'b01, 2'b00);
    repeat (7) push(2'b11, 2'b00);
    check("fill_count", 64'(bus.count_o), 64'd15);
    check("fill_allowin", 64'(bus.allowin_o), 64'd0);
    push(2'b01, 2'b00);
    check("drop_count", 64'(bus.count_o), 64'd15);
    push(2'b00, 2'b01);
    push(2'b01, 2'b00);
    check("refill_count", 64'(bus.count_o), 64'd15);
    push(2'b00, 2'b01);
    for (int i = 0; i < 20; i++) begin
      push(2'b11, 2'b11);
      check("steady_count", 64'(bus.count_o), 64'd14);
    end

    // Dual writes from empty reach DEPTH
    cyc(1'b0, 1'b1, 2'b00, 2'b00, '0, '0);
    repeat (8) push(2'b11, 2'b00);
    check("full_flag", 64'(bus.full_o), 64'd1);
    check("full_allowin", 64'(bus.allowin_o), 64'd0);
    push(2'b11, 2'b11);
    check("full_pop_count", 64'(bus.count_o), 64'd14);

    // Simultaneous write and pop at count 5
    cyc(1'b0, 1'b1, 2'b00, 2'b00, '0, '0);
    push(2'b11, 2'b00);
    push(2'b11, 2'b00);
    push(2'b01, 2'b00);
    exp_d = mq[1];
    push(2'b11, 2'b01);
    check("simul_count", 64'(bus.count_o), 64'd6);
    check("simul_rdata0", 64'(bus.rdata0_o), 64'(exp_d));

    // Illegal lane codes change nothing
    push(2'b10, 2'b00);
    check("ill_we_count", 64'(bus.count_o), 64'd6);
    check("ill_we_rdata0", 64'(bus.rdata0_o), 64'(exp_d));
    push(2'b00, 2'b10);
    check("ill_pop_count", 64'(bus.count_o), 64'd6);

    // Flush beats write and pop
    cyc(1'b0, 1'b1, 2'b00, 2'b00, '0, '0);
    repeat (4) push(2'b11, 2'b00);
    push(2'b01, 2'b00);
    check("pre_flush_count", 64'(bus.count_o), 64'd9);
    cyc(1'b0, 1'b1, 2'b11, 2'b11, 32'hDEAD, 32'hBEEF);
    check("flush_count", 64'(bus.count_o), 64'd0);
    check("flush_rvalid", 64'(bus.rvalid_o), 64'd0);
    check("flush_allowin", 64'(bus.allowin_o), 64'd1);
    cyc(1'b0, 1'b0, 2'b01, 2'b00, 32'hB0, '0);
    check("post_flush_rdata0", 64'(bus.rdata0_o), 64'hB0);
    check("post_flush_rvalid", 64'(bus.rvalid_o), 64'd1);

    // Reset mid-operation beats a dual write
    repeat (3) push(2'b11, 2'b00);
    check("pre_rst_count", 64'(bus.count_o), 64'd7);
    cyc(1'b1, 1'b0, 2'b11, 2'b00, 32'h1, 32'h2);
    check("rst_mid_count", 64'(bus.count_o), 64'd0);
    check("rst_mid_empty", 64'(bus.empty_o), 64'd1);
    check("rst_mid_rvalid", 64'(bus.rvalid_o), 64'd0);

    // Random traffic, including illegal codes, flushes and resets
    for (int i = 0; i < 600; i++) begin
      logic [1:0] we, pop;
      logic r, f;
      r   = ($urandom_range(0, 199) == 0);
      f   = ($urandom_range(0, 59) == 0);
      we  = 2'($urandom_range(0, 3));
      pop = 2'($urandom_range(0, 3));
      if ((i / 64) % 2 == 0 && pop == 2'b11) pop = 2'b00;
      cyc(r, f, we, pop, $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
